axi_rr_arbiter: RTL

//  Per-slave address/response-phase arbiter for the AXI crossbar, successor to the fixed-order arbiter.

---
 rtl/axi_rr_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - per-slave read/write ownership arbiter with round-robin or fixed priority
module axi_rr_arbiter #(
    parameter int NUM_M         = 3,
    parameter int NUM_S         = 6,
    parameter int ARB_MODE      = 1,
    parameter int RW_CONCURRENT = 1,
    parameter int MIDX_BITS     = $clog2(NUM_M + 1),
    parameter int SIDX_BITS     = $clog2(NUM_S + 2)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_S:0][NUM_M-1:0]           R_REQ,
    input  logic [NUM_S:0][NUM_M-1:0]           W_REQ,
    input  logic [NUM_S:0]                      ARREADY_S,
    input  logic [NUM_S:0]                      AWREADY_S,
    input  logic [NUM_M-1:0]                    RREADY_M,
    input  logic [NUM_M-1:0]                    BREADY_M,
    input  logic [NUM_S:0]                      RVALID_S,
    input  logic [NUM_S:0]                      RLAST_S,
    input  logic [NUM_S:0]                      BVALID_S,
    output logic [NUM_S:0][MIDX_BITS-1:0]       SRIdx,
    output logic [NUM_S:0][MIDX_BITS-1:0]       SWIdx,
    output logic [NUM_M-1:0][SIDX_BITS-1:0]     MRIdx,
    output logic [NUM_M-1:0][SIDX_BITS-1:0]     MWIdx,
    output logic [NUM_S:0]                      R_BUSY,
    output logic [NUM_S:0]                      W_BUSY
);

    localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [NUM_S:0][MIDX_BITS-1:0] r_rown, r_wown;
    logic [NUM_S:0][PTR_W-1:0]     r_rptr, r_wptr;
    logic [NUM_S:0][MIDX_BITS-1:0] w_rwin, w_wwin;
    logic [NUM_S:0]                w_rdone, w_wdone, w_busy;

    // Descending scan so the last hit is the first candidate in priority order.
    function automatic logic [MIDX_BITS-1:0] f_pick(input logic [NUM_M-1:0] cand,
                                                    input logic [PTR_W-1:0] ptr);
        logic [MIDX_BITS-1:0] win;
        int k;
        win = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            k = (ARB_MODE != 0) ? int'(ptr) + i : i;
            if (k >= NUM_M) k = k - NUM_M;
            if (cand[k]) win = MIDX_BITS'(k + 1);
        end
        return win;
    endfunction

    function automatic logic [PTR_W-1:0] f_next(input logic [MIDX_BITS-1:0] win);
        return (win >= MIDX_BITS'(NUM_M)) ? '0 : PTR_W'(win);
    endfunction

    function automatic logic f_hs(input logic [MIDX_BITS-1:0] own,
                                  input logic [NUM_M-1:0] ready);
        logic hit;
        hit = 1'b0;
        for (int m = 0; m < NUM_M; m++)
            if (own == MIDX_BITS'(m + 1) && ready[m]) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        w_rwin  = '0;
        w_wwin  = '0;
        w_rdone = '0;
        w_wdone = '0;
        w_busy  = '0;
        SRIdx   = '0;
        SWIdx   = '0;
        R_BUSY  = '0;
        W_BUSY  = '0;
        MRIdx   = '0;
        MWIdx   = '0;
        for (int s = 0; s <= NUM_S; s++) begin
            w_rwin[s]  = f_pick(R_REQ[s] & {NUM_M{ARREADY_S[s] & rst_n}}, r_rptr[s]);
            w_wwin[s]  = f_pick(W_REQ[s] & {NUM_M{AWREADY_S[s] & rst_n}}, r_wptr[s]);
            w_rdone[s] = RVALID_S[s] & RLAST_S[s] & f_hs(r_rown[s], RREADY_M);
            w_wdone[s] = BVALID_S[s] & f_hs(r_wown[s], BREADY_M);
            w_busy[s]  = (r_rown[s] != '0) || (r_wown[s] != '0);
            R_BUSY[s]  = (r_rown[s] != '0);
            W_BUSY[s]  = (r_wown[s] != '0);
            if (RW_CONCURRENT != 0) begin
                SRIdx[s] = (r_rown[s] != '0) ? r_rown[s] : w_rwin[s];
                SWIdx[s] = (r_wown[s] != '0) ? r_wown[s] : w_wwin[s];
            end else begin
                // Shared owner: an idle slave offers itself to the read winner first.
                SRIdx[s] = w_busy[s] ? r_rown[s] : w_rwin[s];
                SWIdx[s] = w_busy[s] ? r_wown[s] : ((w_rwin[s] != '0) ? '0 : w_wwin[s]);
            end
        end
        for (int m = 0; m < NUM_M; m++) begin
            for (int s = 0; s <= NUM_S; s++) begin
                if (SRIdx[s] == MIDX_BITS'(m + 1)) MRIdx[m] = SIDX_BITS'(s + 1);
                if (SWIdx[s] == MIDX_BITS'(m + 1)) MWIdx[m] = SIDX_BITS'(s + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rown <= '0;
            r_wown <= '0;
            r_rptr <= '0;
            r_wptr <= '0;
        end else begin
            for (int s = 0; s <= NUM_S; s++) begin
                if (RW_CONCURRENT != 0) begin
                    if (r_rown[s] == '0 || w_rdone[s]) begin
                        r_rown[s] <= w_rwin[s];
                        if (w_rwin[s] != '0) r_rptr[s] <= f_next(w_rwin[s]);
                    end
                    if (r_wown[s] == '0 || w_wdone[s]) begin
                        r_wown[s] <= w_wwin[s];
                        if (w_wwin[s] != '0) r_wptr[s] <= f_next(w_wwin[s]);
                    end
                end else if (!w_busy[s] || w_rdone[s] || w_wdone[s]) begin
                    r_rown[s] <= w_rwin[s];
                    r_wown[s] <= (w_rwin[s] != '0) ? '0 : w_wwin[s];
                    if (w_rwin[s] != '0)
                        r_rptr[s] <= f_next(w_rwin[s]);
                    else if (w_wwin[s] != '0)
                        r_wptr[s] <= f_next(w_wwin[s]);
                end
            end
        end
    end

endmodule
